// File: rtl/eth_crc_pkg.sv
// Shared constants, result bundle and byte-wise CRC-32 step for the
// Ethernet FCS stream checker.
package eth_crc_pkg;

  // Reflected IEEE 802.3 polynomial, preset and the register value a good
  // frame leaves once its FCS has been shifted through (no final XOR).
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  // Frame length accumulator ceiling.
  localparam logic [15:0] LEN_MAX = 16'hFFFF;

  // Per-frame verdict, registered for exactly one cycle after the last beat.
  typedef struct packed {
    logic ok;
    logic err;
    logic runt;
  } result_t;

  // One byte through the reflected CRC, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_nbyte.sv
// Combinational CRC-32 update over the first nbytes bytes of a data word,
// byte 0 (bits [7:0]) first. nbytes == 0 passes crc_in straight through.
module eth_crc32_nbyte
  import eth_crc_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int NB_W  = $clog2(BYTES + 1)
) (
  input  logic [31:0]        crc_in,
  input  logic [8*BYTES-1:0] data,
  input  logic [NB_W-1:0]    nbytes,
  output logic [31:0]        crc_out
);

  // Chain the byte step across the word, stopping after nbytes bytes.
  always_comb begin
    // NOTE: crc_out gets a value before the loop so every path assigns it;
    // without that default the tool would infer a latch.
    crc_out = crc_in;
    for (int i = 0; i < BYTES; i++) begin
      if (NB_W'(i) < nbytes) begin
        crc_out = crc32_byte(crc_out, data[8*i +: 8]);
      end
    end
  end

endmodule

// File: rtl/eth_crc32_stream_chk_w.sv
// Streaming Ethernet FCS checker: runs CRC-32 over every accepted beat,
// reports ok/err/runt one cycle after the last beat, and keeps saturating
// frame statistics.
module eth_crc32_stream_chk_w
  import eth_crc_pkg::*;
#(
  parameter int BYTES   = 4,
  parameter int MIN_LEN = 64,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [8*BYTES-1:0] s_data,
  input  logic [BYTES-1:0]   s_keep,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  input  logic               clr_stats,
  output logic               crc_ok_pulse,
  output logic               crc_err_pulse,
  output logic               runt_pulse,
  output logic [15:0]        frame_len,
  output logic [CNT_W-1:0]   good_cnt,
  output logic [CNT_W-1:0]   bad_cnt,
  output logic [CNT_W-1:0]   runt_cnt
);

  localparam int              NB_W      = $clog2(BYTES + 1);
  localparam logic [16:0]     MIN_LEN_X = 17'(MIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic            accept;
  logic            frame_done;
  logic            keep_open;
  logic [NB_W-1:0] keep_run;
  logic [NB_W-1:0] nbytes;
  logic [31:0]     crc_reg;
  logic [31:0]     crc_next;
  logic [15:0]     len_acc;
  logic [16:0]     len_sum;
  logic [15:0]     len_next;
  logic            frame_ok;
  logic            frame_runt;
  result_t         res_q;

  // Back-pressure comes straight from enable; nothing inside ever stalls.
  assign s_ready    = enable;
  assign accept     = s_valid && enable;
  assign frame_done = accept && s_last;

  // Length of the LSB-contiguous run of set keep bits; anything above the
  // first clear bit is ignored.
  always_comb begin
    keep_run  = '0;
    keep_open = 1'b1;
    for (int i = 0; i < BYTES; i++) begin
      if (keep_open && s_keep[i]) begin
        keep_run = keep_run + NB_W'(1);
      end else begin
        keep_open = 1'b0;
      end
    end
  end

  // Non-last beats always carry a full word.
  assign nbytes = s_last ? keep_run : NB_W'(BYTES);

  eth_crc32_nbyte #(
    .BYTES (BYTES),
    .NB_W  (NB_W)
  ) u_crc (
    .crc_in  (crc_reg),
    .data    (s_data),
    .nbytes  (nbytes),
    .crc_out (crc_next)
  );

  // Running length including this beat, pinned at LEN_MAX.
  assign len_sum  = {1'b0, len_acc} + 17'(nbytes);
  assign len_next = len_sum[16] ? LEN_MAX : len_sum[15:0];

  // Verdicts for the frame closing on this beat. The runt test is written
  // as len + 1 <= MIN_LEN so MIN_LEN = 0 stays a meaningful comparison.
  assign frame_ok   = (crc_next == CRC_RESIDUE);
  assign frame_runt = (({1'b0, len_next} + 17'd1) <= MIN_LEN_X);

  // CRC and length accumulators: advance on each accepted beat and re-arm
  // on the last one so the next cycle can start a new frame immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      crc_reg <= CRC_INIT;
      len_acc <= '0;
    end else if (accept) begin
      if (s_last) begin
        crc_reg <= CRC_INIT;
        len_acc <= '0;
      end else begin
        crc_reg <= crc_next;
        len_acc <= len_next;
      end
    end
  end

  // One-cycle verdict pulses and the captured length of the closed frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q     <= '0;
      frame_len <= '0;
    end else begin
      res_q.ok   <= frame_done &&  frame_ok;
      res_q.err  <= frame_done && !frame_ok;
      res_q.runt <= frame_done &&  frame_runt;
      if (frame_done) begin
        frame_len <= len_next;
      end
    end
  end

  assign crc_ok_pulse  = res_q.ok;
  assign crc_err_pulse = res_q.err;
  assign runt_pulse    = res_q.runt;

  // Saturating statistics, updated on the same edge that raises the pulse;
  // a coincident clear takes priority over any increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
      runt_cnt <= '0;
    end else if (clr_stats) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
      runt_cnt <= '0;
    end else if (frame_done) begin
      if (frame_ok && (good_cnt != CNT_MAX)) begin
        good_cnt <= good_cnt + 1'b1;
      end
      if (!frame_ok && (bad_cnt != CNT_MAX)) begin
        bad_cnt <= bad_cnt + 1'b1;
      end
      if (frame_runt && (runt_cnt != CNT_MAX)) begin
        runt_cnt <= runt_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eth_crc32_stream_chk_w.sv
// Self-checking bench: two checker instances (MIN_LEN 64 / CNT_W 32 and
// MIN_LEN 0 / CNT_W 2) share one stream and are compared every cycle
// against a frame-level model built from byte queues.
module tb_eth_crc32_stream_chk_w;

  typedef logic [7:0] u8;
  typedef u8 bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_valid;
  logic        s_last;
  logic        clr_stats;

  logic        ready_a, ok_a, err_a, runt_a;
  logic [15:0] len_a;
  logic [31:0] good_a, bad_a, runtc_a;
  logic        ready_b, ok_b, err_b, runt_b;
  logic [15:0] len_b;
  logic [1:0]  good_b, bad_b, runtc_b;

  eth_crc32_stream_chk_w #(.BYTES(4), .MIN_LEN(64), .CNT_W(32)) u_dut_a (
    .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_keep(s_keep),
    .s_valid(s_valid), .s_last(s_last), .s_ready(ready_a), .clr_stats(clr_stats),
    .crc_ok_pulse(ok_a), .crc_err_pulse(err_a), .runt_pulse(runt_a),
    .frame_len(len_a), .good_cnt(good_a), .bad_cnt(bad_a), .runt_cnt(runtc_a)
  );

  eth_crc32_stream_chk_w #(.BYTES(4), .MIN_LEN(0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_keep(s_keep),
    .s_valid(s_valid), .s_last(s_last), .s_ready(ready_b), .clr_stats(clr_stats),
    .crc_ok_pulse(ok_b), .crc_err_pulse(err_b), .runt_pulse(runt_b),
    .frame_len(len_b), .good_cnt(good_b), .bad_cnt(bad_b), .runt_cnt(runtc_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bq_t         cur_q;
  logic        m_ok, m_err, m_runt_a, m_runt_b;
  logic [15:0] m_len;
  logic [31:0] mg_a, mb_a, mr_a;
  logic [1:0]  mg_b, mb_b, mr_b;

  // Register value after shifting a whole byte sequence through the
  // reflected CRC-32 from the all-ones preset.
  function automatic logic [31:0] crc_of(input bq_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic int keep_bytes(input logic [3:0] k);
    int n;
    n = 0;
    while (n < 4 && k[n]) n++;
    return n;
  endfunction

  function automatic bq_t good_frame(input int plen);
    bq_t f;
    logic [31:0] fcs;
    for (int i = 0; i < plen; i++) f.push_back(u8'($urandom));
    fcs = ~crc_of(f);
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    return f;
  endfunction

  function automatic bq_t s1_frame();
    bq_t f;
    string s;
    s = "123456789";
    for (int i = 0; i < 9; i++) f.push_back(u8'(s[i]));
    f.push_back(8'h26); f.push_back(8'h39); f.push_back(8'hF4); f.push_back(8'hCB);
    return f;
  endfunction

  task automatic model_reset();
    cur_q.delete();
    {m_ok, m_err, m_runt_a, m_runt_b} = '0;
    m_len = '0;
    {mg_a, mb_a, mr_a} = '0;
    {mg_b, mb_b, mr_b} = '0;
  endtask

  task automatic model_edge(input logic acc);
    int n;
    int len;
    logic good;
    {m_ok, m_err, m_runt_a, m_runt_b} = '0;
    if (acc) begin
      n = s_last ? keep_bytes(s_keep) : 4;
      for (int i = 0; i < n; i++) cur_q.push_back(s_data[8*i +: 8]);
      if (s_last) begin
        len = cur_q.size();
        if (len > 65535) len = 65535;
        good     = (crc_of(cur_q) == 32'hDEBB20E3);
        m_len    = 16'(len);
        m_ok     = good;
        m_err    = !good;
        m_runt_a = (len < 64);
        m_runt_b = (len < 0);
        if (good  && mg_a != '1) mg_a++;
        if (!good && mb_a != '1) mb_a++;
        if (m_runt_a && mr_a != '1) mr_a++;
        if (good  && mg_b != '1) mg_b++;
        if (!good && mb_b != '1) mb_b++;
        if (m_runt_b && mr_b != '1) mr_b++;
        cur_q.delete();
      end
    end
    if (clr_stats) begin
      {mg_a, mb_a, mr_a} = '0;
      {mg_b, mb_b, mr_b} = '0;
    end
  endtask

  task automatic compare_all();
    check("ready_a", 64'(ready_a), 64'(enable));
    check("ready_b", 64'(ready_b), 64'(enable));
    check("flags_a", 64'({ok_a, err_a, runt_a}), 64'({m_ok, m_err, m_runt_a}));
    check("flags_b", 64'({ok_b, err_b, runt_b}), 64'({m_ok, m_err, m_runt_b}));
    check("len_a",   64'(len_a),   64'(m_len));
    check("len_b",   64'(len_b),   64'(m_len));
    check("good_a",  64'(good_a),  64'(mg_a));
    check("bad_a",   64'(bad_a),   64'(mb_a));
    check("runt_a",  64'(runtc_a), 64'(mr_a));
    check("good_b",  64'(good_b),  64'(mg_b));
    check("bad_b",   64'(bad_b),   64'(mb_b));
    check("runt_b",  64'(runtc_b), 64'(mr_b));
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic tick();
    logic acc;
    acc = s_valid && enable;
    @(posedge clk);
    if (!rst) model_edge(acc);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    s_valid   = 1'b0;
    s_last    = 1'b0;
    clr_stats = 1'b0;
    rst       = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle(input int n, input bit rnd_en);
    s_valid = 1'b0;
    s_last  = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_data = $urandom;
      enable = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
  endtask

  task automatic do_clear();
    s_valid   = 1'b0;
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
  endtask

  // Drive a frame as 4-byte beats; returns right after the tick in which
  // the last beat was accepted (the verdict cycle).
  task automatic send_frame(input bq_t f, input bit rnd_en, input bit junk,
                            input bit zero_tail, input bit clr_last);
    int nb, nbd, nbt, n;
    logic        last;
    logic        acc;
    logic [31:0] d;
    logic [3:0]  k;
    nb  = f.size();
    nbd = (nb + 3) / 4;
    nbt = (zero_tail || nb == 0) ? nbd + 1 : nbd;
    for (int b = 0; b < nbt; b++) begin
      last = (b == nbt - 1);
      n    = (b < nbd) ? (((nb - 4*b) >= 4) ? 4 : nb - 4*b) : 0;
      d    = $urandom;
      for (int i = 0; i < n; i++) d[8*i +: 8] = f[4*b + i];
      if (!last) begin
        k = 4'($urandom);
      end else begin
        k = 4'((1 << n) - 1);
        if (junk && n < 4) k = k | (4'($urandom) & ~4'((1 << (n + 1)) - 1));
      end
      s_valid   = 1'b1;
      s_data    = d;
      s_keep    = k;
      s_last    = last;
      clr_stats = clr_last && last;
      for (int t = 0; t < 64; t++) begin
        enable = (rnd_en && t < 16) ? 1'($urandom_range(0, 1)) : 1'b1;
        acc    = enable;
        tick();
        clr_stats = 1'b0;
        if (acc) break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    bq_t f;
    int  plen;
    rst = 1'b1; enable = 1'b0; s_data = '0; s_keep = '0;
    s_valid = 1'b0; s_last = 1'b0; clr_stats = 1'b0;

    do_reset();
    check("rst_len", 64'(len_a), 64'd0);
    check("rst_good", 64'(good_a), 64'd0);
    idle(2, 1'b0);

    // Scenario 1: reference frame, keep=0001 on the last beat.
    send_frame(s1_frame(), 1'b0, 1'b0, 1'b0, 1'b0);
    check("s1_ok",   64'({ok_b, err_b}), 64'b10);
    check("s1_len",  64'(len_b), 64'd13);
    check("s1_good", 64'(good_b), 64'd1);
    check("s1_runt_a", 64'(runt_a), 64'd1);
    idle(1, 1'b0);
    check("s1_pulse_gone", 64'(ok_b), 64'd0);

    // Scenario 2: one flipped bit.
    f = s1_frame();
    f[5] = f[5] ^ 8'h10;
    send_frame(f, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s2_err", 64'({ok_b, err_b}), 64'b01);
    check("s2_bad", 64'(bad_b), 64'd1);
    idle(1, 1'b0);

    // Scenario 3: two 64-byte good frames back to back, then a 63-byte one.
    do_clear();
    f = good_frame(60);
    send_frame(f, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s3_ok1", 64'({ok_a, runt_a}), 64'b10);
    send_frame(f, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s3_ok2", 64'({ok_a, runt_a}), 64'b10);
    check("s3_good", 64'(good_a), 64'd2);
    check("s3_runtc", 64'(runtc_a), 64'd0);
    send_frame(good_frame(59), 1'b0, 1'b0, 1'b0, 1'b0);
    check("min_len_minus1", 64'({ok_a, runt_a}), 64'b11);

    // Zero-keep-only frame, then a good frame closed by a zero-keep beat.
    f.delete();
    send_frame(f, 1'b0, 1'b0, 1'b1, 1'b0);
    check("keep0_len", 64'(len_a), 64'd0);
    check("keep0_flags", 64'({ok_a, err_a, runt_a}), 64'b011);
    send_frame(good_frame(64), 1'b0, 1'b0, 1'b1, 1'b0);
    check("keep0_tail_ok", 64'({ok_a, len_a}), {47'd0, 1'b1, 16'd68});

    // Scenario 4: enable toggling during the reference frame.
    idle(3, 1'b1);
    send_frame(s1_frame(), 1'b1, 1'b0, 1'b0, 1'b0);
    check("s4_ok", 64'({ok_b, len_b}), {47'd0, 1'b1, 16'd13});

    // Scenario 5: reset mid-frame, then the reference frame.
    s_valid = 1'b1; s_last = 1'b0; enable = 1'b1;
    s_data = $urandom; tick();
    s_data = $urandom; tick();
    do_reset();
    send_frame(s1_frame(), 1'b0, 1'b0, 1'b0, 1'b0);
    check("s5_counts", 64'({good_a, bad_a}), {32'd1, 32'd0});
    check("s5_ok", 64'(ok_a), 64'd1);

    // Scenario 6: narrow counters saturate, coincident clear wins.
    do_clear();
    f = s1_frame();
    f[0] = f[0] ^ 8'h01;
    for (int i = 0; i < 5; i++) send_frame(f, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s6_sat", 64'(bad_b), 64'd3);
    send_frame(f, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s6_clr", 64'(bad_b), 64'd0);
    check("s6_err", 64'(err_b), 64'd1);

    // Length accumulator saturation.
    f.delete();
    for (int i = 0; i < 65540; i++) f.push_back(u8'($urandom));
    send_frame(f, 1'b0, 1'b0, 1'b0, 1'b0);
    check("len_sat", 64'(len_a), 64'hFFFF);

    // Randomized traffic.
    for (int fr = 0; fr < 80; fr++) begin
      plen = $urandom_range(0, 90);
      f = good_frame(plen);
      if ($urandom_range(0, 1) == 1) begin
        int bi;
        bi = $urandom_range(0, f.size() - 1);
        f[bi] = f[bi] ^ u8'(1 << $urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) f.delete();
      send_frame(f, 1'b1, 1'b1,
                 (f.size() % 4 == 0) && ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) do_clear();
      idle($urandom_range(0, 2), 1'b1);
    end

    idle(2, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
